// File: rtl/mdr_pkg.sv
// rtl/mdr_pkg.sv - shared types and helpers for the parametrised multiply/divide/sqrt unit
//
// Holds the operation and FSM state enums and the per-operation iteration
// count used to preload the iteration counter.
package mdr_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_Y,
    S_CHECK,
    S_COMPUTE,
    S_FIX,
    S_DONE
  } state_e;

  // Square root retires two radicand bits per iteration; the others one bit.
  function automatic int iter_count(op_e op, int width);
    return (op == OP_SQRT) ? width / 2 : width;
  endfunction

endpackage

// File: rtl/mdr_iter_core.sv
// rtl/mdr_iter_core.sv - unsigned iterative shift-add multiply, restoring divide, non-restoring sqrt
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   op              operation, held stable by the caller while stepping
//   init            load a/b into the working registers
//   step            perform one iteration
//   a, b            unsigned magnitudes (MUL: a*b, DIV: a/b, SQRT: sqrt(a))
//   raw_result      unsigned product / quotient / root
//   raw_rem         unsigned division or root remainder
module mdr_iter_core
  import mdr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  op_e                op,
  input  logic               init,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] raw_result,
  output logic [WIDTH-1:0]   raw_rem
);

  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 2;   // signed partial remainder of the sqrt

  // MUL: {hi,lo} is the accumulator with the multiplier shifting out of lo.
  // DIV: hi is the partial remainder, lo the dividend shifting into quotient.
  logic [WIDTH-1:0] hi, lo;
  logic [RW-1:0]    sr;         // sqrt partial remainder (two's complement)
  logic [HW-1:0]    sq;         // sqrt partial root
  logic [WIDTH-1:0] sd;         // radicand, consumed two bits at a time

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [RW-1:0]    sr_sh, sr_nx;
  logic [HW-1:0]    sq_nx;
  logic [HW:0]      sq_fix;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, b};
    div_diff = div_sh[WIDTH-1:0] - b;
    sr_sh    = {sr[HW-1:0], sd[WIDTH-1 -: 2]};
    // Non-restoring step: subtract 4Q+1 after a non-negative remainder,
    // otherwise add 4Q+3.
    sr_nx    = sr[RW-1] ? sr_sh + {sq, 2'b11} : sr_sh - {sq, 2'b01};
    sq_nx    = {sq[HW-2:0], ~sr_nx[RW-1]};
    // A final negative remainder is restored by adding 2Q+1.
    sq_fix   = sr[RW-1] ? sr[HW:0] + {sq, 1'b1} : sr[HW:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
      sr <= '0;
      sq <= '0;
      sd <= '0;
    end else if (init) begin
      hi <= '0;
      lo <= (op == OP_MUL) ? b : a;
      sr <= '0;
      sq <= '0;
      sd <= a;
    end else if (step) begin
      case (op)
        OP_MUL: {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
        OP_DIV: begin
          hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], div_ge};
        end
        OP_SQRT: begin
          sr <= sr_nx;
          sq <= sq_nx;
          sd <= {sd[WIDTH-3:0], 2'b00};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    raw_result = '0;
    raw_rem    = '0;
    case (op)
      OP_MUL:  raw_result = {hi, lo};
      OP_DIV: begin
        raw_result = {{WIDTH{1'b0}}, lo};
        raw_rem    = hi;
      end
      OP_SQRT: begin
        raw_result = {{(2*WIDTH-HW){1'b0}}, sq};
        raw_rem    = {{(WIDTH-HW-1){1'b0}}, sq_fix};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdr_param.sv
// rtl/mdr_param.sv - parametrised iterative multiply / divide / square-root coprocessor
//
// WIDTH must be even and at least 4.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           request pulse, accepted in IDLE or DONE
//   load            operand valid while load_x or load_y is high
//   op              00 MUL, 01 DIV, 10 SQRT, 11 reserved (captured with start)
//   signed_mode     two's-complement operands (captured with start)
//   data            operand bus
//   error           operation failed, valid while ready=1
//   load_x, load_y  waiting for operand X / Y
//   busy            any state other than IDLE and DONE
//   ready           result valid
//   result          product / quotient / root
//   remainder       division or root remainder
module mdr_param
  import mdr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load,
  input  logic [1:0]         op,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   data,
  output logic               error,
  output logic               load_x,
  output logic               load_y,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder
);

  localparam int N_MUL  = iter_count(OP_MUL, WIDTH);
  localparam int N_SQRT = iter_count(OP_SQRT, WIDTH);
  localparam int CW     = $clog2(N_MUL + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state, state_n;
  op_e                op_r;
  logic               sm_r;
  logic [WIDTH-1:0]   x_r, y_r;
  logic               neg_res, neg_rem;
  logic [CW-1:0]      cnt;

  logic               x_neg, y_neg, chk_err;
  logic [WIDTH-1:0]   mag_x, mag_y;
  logic               core_init, core_step;
  logic [2*WIDTH-1:0] raw_result, fix_result;
  logic [WIDTH-1:0]   raw_rem, fix_rem, quo_s;

  always_comb begin
    x_neg   = sm_r & x_r[WIDTH-1];
    y_neg   = sm_r & y_r[WIDTH-1];
    mag_x   = x_neg ? -x_r : x_r;
    mag_y   = y_neg ? -y_r : y_r;
    chk_err = (op_r == OP_RSVD)
            | ((op_r == OP_DIV) & (y_r == '0))
            | ((op_r == OP_DIV) & sm_r & (x_r == MIN_NEG) & (y_r == '1))
            | ((op_r == OP_SQRT) & x_neg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = S_LOAD_X;
      S_LOAD_X:       if (load) state_n = (op_r == OP_SQRT) ? S_CHECK : S_LOAD_Y;
      S_LOAD_Y:       if (load) state_n = S_CHECK;
      S_CHECK:        state_n = chk_err ? S_DONE : S_COMPUTE;
      S_COMPUTE:      if (cnt == CW'(1)) state_n = S_FIX;
      S_FIX:          state_n = S_DONE;
      default:        state_n = S_IDLE;
    endcase
  end

  assign core_init = (state == S_CHECK) & ~chk_err;
  assign core_step = (state == S_COMPUTE);

  mdr_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .op         (op_r),
    .init       (core_init),
    .step       (core_step),
    .a          (mag_x),
    .b          (mag_y),
    .raw_result (raw_result),
    .raw_rem    (raw_rem)
  );

  // Sign correction applied in FIX. Signed quotients fit in WIDTH bits once
  // the MIN/-1 case is rejected, so sign-extending quo_s is exact.
  always_comb begin
    fix_result = '0;
    fix_rem    = '0;
    quo_s      = neg_res ? -raw_result[WIDTH-1:0] : raw_result[WIDTH-1:0];
    case (op_r)
      OP_MUL:  fix_result = neg_res ? -raw_result : raw_result;
      OP_DIV: begin
        fix_result = {{WIDTH{sm_r & quo_s[WIDTH-1]}}, quo_s};
        fix_rem    = neg_rem ? -raw_rem : raw_rem;
      end
      OP_SQRT: begin
        fix_result = raw_result;
        fix_rem    = raw_rem;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r      <= OP_MUL;
      sm_r      <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      cnt       <= '0;
      error     <= 1'b0;
      load_x    <= 1'b0;
      load_y    <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      result    <= '0;
      remainder <= '0;
    end else begin
      // Handshake flags are registered from the next state so they line up
      // with the state they describe.
      load_x <= (state_n == S_LOAD_X);
      load_y <= (state_n == S_LOAD_Y);
      busy   <= (state_n != S_IDLE) && (state_n != S_DONE);
      ready  <= (state_n == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_r  <= op_e'(op);
            sm_r  <= signed_mode;
            error <= 1'b0;
          end
        end
        S_LOAD_X: if (load) x_r <= data;
        S_LOAD_Y: if (load) y_r <= data;
        S_CHECK: begin
          if (chk_err) begin
            error     <= 1'b1;
            result    <= '0;
            remainder <= '0;
          end else begin
            neg_res <= (op_r != OP_SQRT) & (x_neg ^ y_neg);
            neg_rem <= (op_r == OP_DIV) & x_neg;
            cnt     <= (op_r == OP_SQRT) ? CW'(N_SQRT) : CW'(N_MUL);
          end
        end
        S_COMPUTE: cnt <= cnt - 1'b1;
        S_FIX: begin
          result    <= fix_result;
          remainder <= fix_rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_param.sv
// tb/tb_mdr_param.sv - self-checking bench for mdr_param at WIDTH=16
module tb_mdr_param;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           load = 1'b0;
  logic [1:0]     op = 2'b00;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   data = '0;
  logic           error, load_x, load_y, busy, ready;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;

  int checks = 0;
  int errors = 0;

  mdr_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load        (load),
    .op          (op),
    .signed_mode (signed_mode),
    .data        (data),
    .error       (error),
    .load_x      (load_x),
    .load_y      (load_y),
    .busy        (busy),
    .ready       (ready),
    .result      (result),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        sm;
    logic [15:0] x;
    logic [15:0] y;
    logic        err;
    logic [31:0] res;
    logic [15:0] rem;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] o, logic s, logic [15:0] x, logic [15:0] y,
                              logic e, logic [31:0] r, logic [15:0] m, int lat);
    vec_t v;
    v.op = o; v.sm = s; v.x = x; v.y = y; v.err = e; v.res = r; v.rem = m; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [1:0] o, input logic s, input logic [15:0] x,
                                input logic [15:0] y, output logic e,
                                output logic [31:0] r, output logic [15:0] m);
    longint sx, sy, q, rr;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    e = 1'b0; r = '0; m = '0;
    case (o)
      2'b00: begin q = sx * sy; r = q[31:0]; end
      2'b01: begin
        if (y == 16'h0 || (s && x == 16'h8000 && y == 16'hFFFF)) e = 1'b1;
        else begin q = sx / sy; rr = sx % sy; r = q[31:0]; m = rr[15:0]; end
      end
      2'b10: begin
        if (s && x[15]) e = 1'b1;
        else begin
          rr = 0;
          while ((rr + 1) * (rr + 1) <= sx) rr++;
          r = rr[31:0];
          m = 16'(sx - rr * rr);
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic send(input logic [1:0] o, input logic s, input logic [15:0] x, input logic [15:0] y);
    int n;
    @(negedge clk); start = 1'b1; op = o; signed_mode = s;
    @(negedge clk); start = 1'b0; op = 2'($urandom); signed_mode = 1'($urandom);
    n = 0;
    while (!load_x && n < 10) begin @(negedge clk); n++; end
    chk("load_x_seen", 32'(load_x), 32'd1);
    data = x; load = 1'b1;
    @(negedge clk); load = 1'b0; data = 16'($urandom);
    if (o != 2'b10) begin
      n = 0;
      while (!load_y && n < 10) begin @(negedge clk); n++; end
      chk("load_y_seen", 32'(load_y), 32'd1);
      data = y; load = 1'b1;
      @(negedge clk); load = 1'b0; data = 16'($urandom);
    end
  endtask

  // Counts edges after the last operand capture until ready. At lat==poke a
  // stray start (with a different op) and a stray load are driven.
  task automatic wait_ready(input int poke, output int lat, output bit saw_y);
    lat = 0;
    saw_y = load_y;
    while (!ready && lat < 200) begin
      if (lat == poke) begin
        start = 1'b1; op = 2'b01; signed_mode = 1'b1; load = 1'b1; data = 16'h0001;
      end else begin
        start = 1'b0; load = 1'b0;
      end
      @(negedge clk);
      lat++;
      saw_y = saw_y | load_y;
    end
    start = 1'b0; load = 1'b0;
    chk("ready_seen", 32'(ready), 32'd1);
  endtask

  initial begin
    int  lat;
    bit  sy;
    logic e;
    logic [31:0] r;
    logic [15:0] m;
    logic [1:0] o;
    logic s;
    logic [15:0] x, y;

    tbl.push_back(mk(2'b00, 1'b0, 16'd172,  16'd25,   1'b0, 32'd4300,     16'd0,     18));
    tbl.push_back(mk(2'b01, 1'b0, 16'd172,  16'd25,   1'b0, 32'd6,        16'd22,    18));
    tbl.push_back(mk(2'b01, 1'b1, 16'hFF54, 16'd25,   1'b0, 32'hFFFFFFFA, 16'hFFEA,  18));
    tbl.push_back(mk(2'b00, 1'b1, 16'hFED4, 16'h012C, 1'b0, 32'hFFFEA070, 16'd0,     18));
    tbl.push_back(mk(2'b10, 1'b0, 16'd172,  16'd0,    1'b0, 32'd13,       16'd3,     10));
    tbl.push_back(mk(2'b01, 1'b0, 16'd172,  16'd0,    1'b1, 32'd0,        16'd0,     1));
    tbl.push_back(mk(2'b01, 1'b1, 16'h8000, 16'hFFFF, 1'b1, 32'd0,        16'd0,     1));
    tbl.push_back(mk(2'b10, 1'b1, 16'hFFF0, 16'd0,    1'b1, 32'd0,        16'd0,     1));
    tbl.push_back(mk(2'b11, 1'b0, 16'd5,    16'd7,    1'b1, 32'd0,        16'd0,     1));
    tbl.push_back(mk(2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16'd0,     18));
    tbl.push_back(mk(2'b10, 1'b0, 16'hFFFF, 16'd0,    1'b0, 32'd255,      16'd510,   10));
    tbl.push_back(mk(2'b10, 1'b1, 16'h7FFF, 16'd0,    1'b0, 32'd181,      16'd6,     10));
    tbl.push_back(mk(2'b01, 1'b1, 16'h8000, 16'd1,    1'b0, 32'hFFFF8000, 16'd0,     18));
    tbl.push_back(mk(2'b01, 1'b0, 16'h8000, 16'hFFFF, 1'b0, 32'd0,        16'h8000,  18));
    tbl.push_back(mk(2'b01, 1'b1, 16'd7,    16'hFFFE, 1'b0, 32'hFFFFFFFD, 16'd1,     18));
    tbl.push_back(mk(2'b01, 1'b0, 16'hFFFF, 16'd1,    1'b0, 32'h0000FFFF, 16'd0,     18));

    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", {27'd0, error, load_x, load_y, busy, ready}, 32'd0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].sm, tbl[i].x, tbl[i].y);
      wait_ready(-1, lat, sy);
      chk($sformatf("tbl%0d_error", i), 32'(error), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_result", i), result, tbl[i].res);
      chk($sformatf("tbl%0d_remainder", i), 32'(remainder), 32'(tbl[i].rem));
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
      if (tbl[i].op == 2'b10) chk($sformatf("tbl%0d_no_load_y", i), 32'(sy), 32'd0);
    end

    // start and load pulsed mid-COMPUTE must not disturb the operation
    send(2'b00, 1'b0, 16'd172, 16'd25);
    wait_ready(6, lat, sy);
    chk("busy_start_result", result, 32'd4300);
    chk("busy_start_latency", 32'(lat), 32'd18);
    chk("busy_start_error", 32'(error), 32'd0);

    // reset in the middle of COMPUTE
    send(2'b00, 1'b1, 16'hFED4, 16'h012C);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_flags", {27'd0, error, load_x, load_y, busy, ready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("midrst_idle", {30'd0, busy, ready}, 32'd0);
    chk("midrst_no_result", result, 32'd0);

    for (int k = 0; k < 60; k++) begin
      o = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      s = 1'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(0, 7))
        0: x = 16'h8000;
        1: y = 16'hFFFF;
        2: y = 16'h0000;
        3: y = 16'($urandom_range(1, 9));
        default: ;
      endcase
      model(o, s, x, y, e, r, m);
      send(o, s, x, y);
      wait_ready(-1, lat, sy);
      chk($sformatf("rnd%0d_error op=%0d s=%0d x=%h y=%h", k, o, s, x, y), 32'(error), 32'(e));
      chk($sformatf("rnd%0d_result", k), result, r);
      chk($sformatf("rnd%0d_remainder", k), 32'(remainder), 32'(m));
      chk($sformatf("rnd%0d_latency", k), 32'(lat), e ? 32'd1 : ((o == 2'b10) ? 32'd10 : 32'd18));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
